// File: rtl/exu_issue_writeback_ctrl_if.sv
// Handshake and bus bundle between the decode side,
// the ExecutionUnit and the register-file writeback port.
interface exu_issue_writeback_ctrl_if;
    logic        iValid;
    logic        oReady;
    logic [1:0]  iExuOp;
    logic [4:0]  iDstReg;
    logic [4:0]  iSrc0Reg;
    logic [4:0]  iSrc1Reg;
    logic        iSrc0Use;
    logic        iSrc1Use;
    logic        oIssue;
    logic [1:0]  oExuOp;
    logic [31:0] iExuResult;
    logic        iZeroFlag;
    logic        iOverflowFlag;
    logic        iNegativeFlag;
    logic        oWbValid;
    logic [4:0]  oWbReg;
    logic [31:0] oWbData;
    logic [2:0]  oWbFlags;
    logic        oIllegal;

    modport master (
        output iValid, iExuOp, iDstReg, iSrc0Reg, iSrc1Reg,
        output iSrc0Use, iSrc1Use, iExuResult,
        output iZeroFlag, iOverflowFlag, iNegativeFlag,
        input  oReady, oIssue, oExuOp,
        input  oWbValid, oWbReg, oWbData, oWbFlags, oIllegal
    );

    modport slave (
        input  iValid, iExuOp, iDstReg, iSrc0Reg, iSrc1Reg,
        input  iSrc0Use, iSrc1Use, iExuResult,
        input  iZeroFlag, iOverflowFlag, iNegativeFlag,
        output oReady, oIssue, oExuOp,
        output oWbValid, oWbReg, oWbData, oWbFlags, oIllegal
    );
endinterface

// File: rtl/exu_issue_writeback_ctrl.sv
// Issue/writeback control for the ExecutionUnit: hazard stalls,
// per-latency in-flight tracking, unit steering and result capture.
module exu_issue_writeback_ctrl #(
    parameter int ALU_LAT = 1,
    parameter int MDU_LAT = 4,
    parameter int FPU_LAT = 3
) (
    input  logic                        iClk,
    input  logic                        iRst,
    exu_issue_writeback_ctrl_if.slave   bus
);
    localparam int MAX_LAT =
        (ALU_LAT > MDU_LAT)
            ? ((ALU_LAT > FPU_LAT) ? ALU_LAT : FPU_LAT)
            : ((MDU_LAT > FPU_LAT) ? MDU_LAT : FPU_LAT);
    localparam int DEPTH = MAX_LAT + 1;

    // Slot k holds the entry with k edges left until capture,
    // so the collision rule keeps one entry per slot.
    typedef struct packed {
        logic       valid;
        logic [1:0] unit;
        logic [4:0] dst;
    } slot_t;

    slot_t       slots [1:DEPTH];
    int          opLat;
    logic        isIllegal;
    logic        collide;
    logic        raw;
    logic        waw;
    logic        issue;
    logic [1:0]  r2Unit;

    assign isIllegal = (bus.iExuOp == 2'b11);

    // Latency of the unit addressed by the incoming op.
    always_comb begin
        opLat = 0;
        case (bus.iExuOp)
            2'b00:   opLat = ALU_LAT;
            2'b01:   opLat = MDU_LAT;
            2'b10:   opLat = FPU_LAT;
            default: opLat = 0;
        endcase
    end

    // Port-collision, RAW and WAW checks against pre-edge entries.
    always_comb begin
        collide = 1'b0;
        raw     = 1'b0;
        waw     = 1'b0;
        r2Unit  = 2'b00;
        for (int k = 1; k <= DEPTH; k++) begin
            if (slots[k].valid) begin
                if (k == opLat + 1)
                    collide = 1'b1;
                if (bus.iSrc0Use && bus.iSrc0Reg != 5'd0
                    && bus.iSrc0Reg == slots[k].dst)
                    raw = 1'b1;
                if (bus.iSrc1Use && bus.iSrc1Reg != 5'd0
                    && bus.iSrc1Reg == slots[k].dst)
                    raw = 1'b1;
                if (bus.iDstReg != 5'd0
                    && bus.iDstReg == slots[k].dst)
                    waw = 1'b1;
                if (k == 2)
                    r2Unit = slots[k].unit;
            end
        end
    end

    assign bus.oReady = ~(bus.iValid & ~isIllegal
                          & (collide | raw | waw));
    assign issue      = ~iRst & bus.iValid & bus.oReady & ~isIllegal;
    assign bus.oIssue = issue;
    assign bus.oExuOp = (issue && opLat == 1) ? bus.iExuOp : r2Unit;

    // Age all entries by one edge and insert the new op at its latency.
    always_ff @(posedge iClk or posedge iRst) begin
        if (iRst) begin
            for (int k = 1; k <= DEPTH; k++)
                slots[k] <= '0;
        end else begin
            for (int k = 1; k < DEPTH; k++)
                slots[k] <= slots[k+1];
            slots[DEPTH] <= '0;
            if (issue)
                slots[opLat] <= {1'b1, bus.iExuOp, bus.iDstReg};
        end
    end

    // Capture the shared result bus for the entry retiring this edge.
    always_ff @(posedge iClk or posedge iRst) begin
        if (iRst) begin
            bus.oWbValid <= 1'b0;
            bus.oWbReg   <= 5'd0;
            bus.oWbData  <= 32'd0;
            bus.oWbFlags <= 3'd0;
            bus.oIllegal <= 1'b0;
        end else begin
            bus.oIllegal <= bus.iValid & isIllegal;
            bus.oWbValid <= 1'b0;
            if (slots[1].valid) begin
                bus.oWbValid <= (slots[1].dst != 5'd0);
                bus.oWbReg   <= slots[1].dst;
                bus.oWbData  <= bus.iExuResult;
                bus.oWbFlags <= (slots[1].unit == 2'b00)
                    ? {bus.iOverflowFlag, bus.iZeroFlag,
                       bus.iNegativeFlag}
                    : 3'b000;
            end
        end
    end
endmodule
